// File: rtl/seq_muldiv_pkg.sv
// Shared types for the sequential multiply/divide unit: FSM state encoding and op codes.
package seq_muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/seq_muldiv_md_step.sv
// One combinational iteration: radix-2 Booth add/sub + arithmetic shift (MUL),
// or one restoring shift/subtract quotient bit on magnitudes (DIV).
module md_step
    import seq_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             op_i,
    input  logic [WIDTH:0]   hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic             qm1_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH:0]   hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             qm1_o
);

    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    // hi carries one guard bit so Booth add/sub of the most negative multiplicand cannot overflow
    assign m_ext   = {m_i[WIDTH-1], m_i};
    assign shifted = {hi_i[WIDTH-1:0], lo_i[WIDTH-1]};
    assign diff    = {1'b0, shifted} - {2'b00, m_i};

    always_comb begin
        sum = hi_i;
        case ({lo_i[0], qm1_i})
            2'b01:   sum = hi_i + m_ext;
            2'b10:   sum = hi_i - m_ext;
            default: sum = hi_i;
        endcase

        if (op_i == OP_MUL) begin
            hi_o  = {sum[WIDTH], sum[WIDTH:1]};
            lo_o  = {sum[0], lo_i[WIDTH-1:1]};
            qm1_o = lo_i[0];
        end else if (!diff[WIDTH+1]) begin
            hi_o  = diff[WIDTH:0];
            lo_o  = {lo_i[WIDTH-2:0], 1'b1};
            qm1_o = qm1_i;
        end else begin
            hi_o  = shifted;
            lo_o  = {lo_i[WIDTH-2:0], 1'b0};
            qm1_o = qm1_i;
        end
    end

endmodule

// File: rtl/seq_muldiv.sv
// Sequential signed multiplier/divider: FSM, iteration down-counter, operand and result registers.
//   state | meaning
//   IDLE  | waiting for Start
//   RUN   | one Booth / restoring iteration per cycle
//   FIX   | apply signs, load result registers
//   DONE  | one-cycle Done pulse, results valid
module seq_muldiv
    import seq_muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             Start,
    input  logic             Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Lo,
    output logic [WIDTH-1:0] Hi,
    output logic             DivZero
);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             op_q;
    logic [WIDTH:0]   hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             qm1_q;
    logic [WIDTH-1:0] m_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             busy_q;
    logic             done_q;
    logic             dz_q;
    logic [WIDTH-1:0] lo_res_q;
    logic [WIDTH-1:0] hi_res_q;

    logic [WIDTH:0]   hi_d;
    logic [WIDTH-1:0] lo_d;
    logic             qm1_d;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] fix_lo;
    logic [WIDTH-1:0] fix_hi;

    md_step #(.WIDTH(WIDTH)) u_step (
        .op_i  (op_q),
        .hi_i  (hi_q),
        .lo_i  (lo_q),
        .qm1_i (qm1_q),
        .m_i   (m_q),
        .hi_o  (hi_d),
        .lo_o  (lo_d),
        .qm1_o (qm1_d)
    );

    // Magnitude of the most negative value wraps to itself, which is correct read as unsigned
    assign abs_a = A[WIDTH-1] ? -A : A;
    assign abs_b = B[WIDTH-1] ? -B : B;

    always_comb begin
        fix_lo = lo_q;
        fix_hi = hi_q[WIDTH-1:0];
        if (op_q == OP_DIV) begin
            fix_lo = neg_quo_q ? -lo_q : lo_q;
            fix_hi = neg_rem_q ? -hi_q[WIDTH-1:0] : hi_q[WIDTH-1:0];
        end
    end

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= OP_MUL;
            hi_q      <= '0;
            lo_q      <= '0;
            qm1_q     <= 1'b0;
            m_q       <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
            lo_res_q  <= '0;
            hi_res_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        op_q  <= Op;
                        dz_q  <= 1'b0;
                        hi_q  <= '0;
                        qm1_q <= 1'b0;
                        cnt_q <= CNT_W'(WIDTH - 1);
                        if (Op == OP_DIV && B == '0) begin
                            dz_q     <= 1'b1;
                            lo_res_q <= '1;
                            hi_res_q <= A;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            lo_q      <= (Op == OP_DIV) ? abs_a : A;
                            m_q       <= (Op == OP_DIV) ? abs_b : B;
                            neg_quo_q <= A[WIDTH-1] ^ B[WIDTH-1];
                            neg_rem_q <= A[WIDTH-1];
                            busy_q    <= 1'b1;
                            state_q   <= RUN;
                        end
                    end
                end
                RUN: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    qm1_q <= qm1_d;
                    if (cnt_q == '0) begin
                        state_q <= FIX;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                FIX: begin
                    lo_res_q <= fix_lo;
                    hi_res_q <= fix_hi;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Busy    = busy_q;
    assign Done    = done_q;
    assign Lo      = lo_res_q;
    assign Hi      = hi_res_q;
    assign DivZero = dz_q;

endmodule
